// File: rtl/snn_input_loader.sv
// snn_input_loader: unpacks UART image bytes LSB-first into the 1-bit
// input-unit RAM, pulses start to the SNN core after a full frame, then
// hands RAM addressing to the core until it reports done.
// Optional feature: define SNN_LOADER_TIMEOUT_EN to discard partial frames
// after TIMEOUT_CYC idle cycles (reported by a frame_err pulse).
module snn_input_loader #(
    parameter int NUM_BYTES = 98,
    parameter int NUM_BITS  = NUM_BYTES * 8
`ifdef SNN_LOADER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1 << 20
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       clr_rx_rdy,
    input  logic [9:0] core_addr,
    input  logic       core_done,
    output logic [9:0] ram_addr,
    output logic       ram_data,
    output logic       ram_we,
    output logic       start,
    output logic       busy,
    output logic       frame_err
);

    localparam logic [9:0] LAST_BIT = 10'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_SHIFT = 2'd1,
        S_START = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;

`ifdef SNN_LOADER_TIMEOUT_EN
    localparam logic [19:0] IDLE_LAST = 20'(TIMEOUT_CYC - 1);
    logic [19:0] idle_q, idle_d;
`endif

    // State, bit counter and shift register (plus idle counter when enabled)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_WAIT;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
`ifdef SNN_LOADER_TIMEOUT_EN
            idle_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
`ifdef SNN_LOADER_TIMEOUT_EN
            idle_q    <= idle_d;
`endif
        end
    end

    // Next-state and outputs; outputs decode the current state so an
    // asynchronous reset drops start/ram_we immediately
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        clr_rx_rdy = 1'b0;
        ram_addr   = bit_cnt_q;
        ram_data   = 1'b0;
        ram_we     = 1'b0;
        start      = 1'b0;
        busy       = 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
        idle_d     = '0;
        frame_err  = 1'b0;
`endif
        unique case (state_q)
            S_WAIT: begin
                // rst_n gate keeps the handshake quiet while held in reset
                if (rx_rdy && rst_n) begin
                    shreg_d    = rx_data;
                    clr_rx_rdy = 1'b1;
                    state_d    = S_SHIFT;
                end
`ifdef SNN_LOADER_TIMEOUT_EN
                else if (bit_cnt_q != '0) begin
                    if (idle_q == IDLE_LAST) begin
                        bit_cnt_d = '0;
                        frame_err = 1'b1;
                    end else begin
                        idle_d = idle_q + 20'd1;
                    end
                end
`endif
            end
            S_SHIFT: begin
                ram_we   = 1'b1;
                ram_data = shreg_q[0];
                shreg_d  = shreg_q >> 1;
                if (bit_cnt_q[2:0] == 3'd7) begin
                    // Last bit of the frame: counter parks at NUM_BITS-1,
                    // START clears it
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = S_START;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 10'd1;
                        state_d   = S_WAIT;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 10'd1;
                end
            end
            S_START: begin
                start     = 1'b1;
                busy      = 1'b1;
                bit_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                ram_addr = core_addr;
                busy     = 1'b1;
                if (core_done) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

`ifndef SNN_LOADER_TIMEOUT_EN
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_snn_input_loader.sv
// Directed testbench for snn_input_loader. Builds with or without
// SNN_LOADER_TIMEOUT_EN; the timeout scenario runs only when it is defined.
module tb_snn_input_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       clr_rx_rdy;
    logic [9:0] core_addr;
    logic       core_done;
    logic [9:0] ram_addr;
    logic       ram_data;
    logic       ram_we;
    logic       start;
    logic       busy;
    logic       frame_err;

`ifdef SNN_LOADER_TIMEOUT_EN
    snn_input_loader #(.TIMEOUT_CYC(100)) dut (
`else
    snn_input_loader dut (
`endif
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy), .core_addr(core_addr), .core_done(core_done),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .start(start), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // RAM model and observation counters, updated only by the monitor
    logic       mem [0:783];
    int         wr_cnt = 0;
    int         start_cnt = 0;
    int         fe_cnt = 0;
    int         addr_err = 0;
    int         busy_bad = 0;
    int         wr_since_rst = 0;
    int         first_addr = -1;
    int         last_wr_addr = -1;
    int         exp_addr = 0;
    logic       busy_m = 1'b0;

    logic [7:0] exp_bytes [0:97];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, inputs change 2ns after rising
    always @(negedge clk) begin
        logic exp_busy;
        if (!rst_n) begin
            exp_addr     = 0;
            wr_since_rst = 0;
            busy_m       = 1'b0;
        end else begin
            if (ram_we) begin
                if (int'(ram_addr) != exp_addr) addr_err++;
                if (ram_addr < 10'd784) mem[ram_addr] = ram_data;
                else addr_err++;
                if (wr_since_rst == 0) first_addr = int'(ram_addr);
                wr_since_rst++;
                wr_cnt++;
                last_wr_addr = int'(ram_addr);
                exp_addr = (ram_addr == 10'd783) ? 0 : int'(ram_addr) + 1;
            end
            if (start) start_cnt++;
            if (frame_err) begin
                fe_cnt++;
                exp_addr     = 0;
                wr_since_rst = 0;
            end
            exp_busy = start ? 1'b1 : busy_m;
            if (busy !== exp_busy) busy_bad++;
            busy_m = exp_busy && !(core_done && !start);
        end
    end

    // Offer one byte; returns 2ns after the accepting edge with the time
    // clr_rx_rdy was seen. keep leaves rx_rdy high for the next byte.
    task automatic send_byte(input logic [7:0] b, input bit keep, output time t_clr);
        bit seen = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        t_clr   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (clr_rx_rdy === 1'b1) begin
                seen  = 1;
                t_clr = $time;
                break;
            end
        end
        if (!seen) check("byte_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
        if (!keep) rx_rdy = 1'b0;
    endtask

    task automatic wait_start(output time t_start);
        bit seen = 0;
        t_start = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (start === 1'b1) begin
                seen    = 1;
                t_start = $time;
                break;
            end
        end
        if (!seen) check("start_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        @(posedge clk); #2;
        core_done = 1'b0;
    endtask

    task automatic verify_frame(input string tag);
        int bad = 0;
        for (int i = 0; i < 784; i++) begin
            logic [7:0] byt;
            byt = exp_bytes[i / 8];
            if (mem[i] !== byt[i % 8]) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        time t_clr, t_prev, t_start;
        int  s0, w0, gap_bad, n_wait;
        bit  seen;

        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
        core_addr = 10'h000; core_done = 1'b0;
        for (int i = 0; i < 784; i++) mem[i] = 1'bx;

        // Reset state
        #1;
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_start_busy_clr", {29'd0, start, busy, clr_rx_rdy}, 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;

        // Frame 1: 98 x A5, start 9 cycles after the last clr_rx_rdy
        for (int k = 0; k < 98; k++) exp_bytes[k] = 8'hA5;
        for (int k = 0; k < 98; k++) send_byte(8'hA5, 1'b0, t_clr);
        wait_start(t_start);
        check("f1_start_latency_ns", 32'(t_start - t_clr), 32'd90);
        repeat (3) @(posedge clk); #2;
        check("f1_start_once", 32'(start_cnt), 32'd1);
        check("f1_write_count", 32'(wr_cnt), 32'd784);
        verify_frame("f1_ram_bits");
        check("f1_ram_bit0", 32'(mem[0]), 32'd1);
        check("f1_ram_bit1", 32'(mem[1]), 32'd0);

        // RUN: address passthrough, rx_rdy ignored until core_done
        core_addr = 10'h1F3; rx_data = 8'h3C; rx_rdy = 1'b1;
        s0 = wr_cnt;
        repeat (3) @(negedge clk);
        check("run_ram_addr", 32'(ram_addr), 32'h1F3);
        check("run_ram_we", 32'(ram_we), 32'd0);
        check("run_no_clr", 32'(clr_rx_rdy), 32'd0);
        check("run_busy", 32'(busy), 32'd1);
        @(posedge clk); #2;
        core_done = 1'b1;
        @(negedge clk);
        check("done_cycle_no_clr", 32'(clr_rx_rdy), 32'd0);
        check("done_cycle_busy", 32'(busy), 32'd1);
        @(posedge clk); #2;
        core_done = 1'b0;
        @(negedge clk);
        check("after_done_clr", 32'(clr_rx_rdy), 32'd1);
        check("after_done_busy", 32'(busy), 32'd0);
        check("after_done_ram_addr", 32'(ram_addr), 32'd0);
        check("run_no_writes", 32'(wr_cnt - s0), 32'd0);
        t_prev = $time;
        @(posedge clk); #2;

        // Frame 2 with rx_rdy held high: clr every 9 cycles, back-to-back frame
        exp_bytes[0] = 8'h3C;
        for (int k = 1; k < 98; k++) exp_bytes[k] = 8'(k * 37 + 5);
        gap_bad = 0;
        for (int k = 1; k < 98; k++) begin
            send_byte(exp_bytes[k], (k != 97), t_clr);
            if (t_clr - t_prev != 90) gap_bad++;
            t_prev = t_clr;
        end
        check("hold_clr_gap_9cyc", 32'(gap_bad), 32'd0);
        wait_start(t_start);
        check("f2_start_latency_ns", 32'(t_start - t_clr), 32'd90);
        check("f2_start_count", 32'(start_cnt), 32'd2);
        check("f2_write_count", 32'(wr_cnt), 32'd1568);
        check("f2_last_addr", 32'(last_wr_addr), 32'd783);
        check("f2_addr_sequence", 32'(addr_err), 32'd0);
        verify_frame("f2_ram_bits");
        pulse_done();
        @(negedge clk);
        check("f2_busy_after_done", 32'(busy), 32'd0);
        @(posedge clk); #2;

        // core_done outside RUN has no effect
        pulse_done();
        check("idle_done_no_start", 32'(start_cnt), 32'd2);

        // Reset mid-frame: 50 bytes, then reset during the 51st byte's shift
        for (int k = 0; k < 50; k++) send_byte(8'hFF, 1'b0, t_clr);
        send_byte(8'hFF, 1'b0, t_clr);
        check("pre_rst_ram_we", 32'(ram_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_ram_we", 32'(ram_we), 32'd0);
        check("async_rst_ram_addr", 32'(ram_addr), 32'd0);
        check("async_rst_start_busy", {30'd0, start, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        s0 = start_cnt;
        w0 = wr_cnt;
        for (int k = 0; k < 98; k++) exp_bytes[k] = 8'(k * 11 + 8'h5A);
        for (int k = 0; k < 98; k++) send_byte(exp_bytes[k], 1'b0, t_clr);
        wait_start(t_start);
        repeat (20) @(posedge clk); #2;
        check("f3_first_addr", 32'(first_addr), 32'd0);
        check("f3_start_once", 32'(start_cnt - s0), 32'd1);
        check("f3_write_count", 32'(wr_cnt - w0), 32'd784);
        check("f3_addr_sequence", 32'(addr_err), 32'd0);
        verify_frame("f3_ram_bits");
        pulse_done();
        @(posedge clk); #2;

`ifdef SNN_LOADER_TIMEOUT_EN
        // Partial frame timeout: 10 bytes then idle; 8 shift cycles + 100 idle
        for (int k = 0; k < 10; k++) send_byte(8'h81, 1'b0, t_clr);
        seen = 0;
        n_wait = 0;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            if (frame_err === 1'b1) begin
                seen   = 1;
                n_wait = i;
                break;
            end
        end
        check("timeout_seen", 32'(seen), 32'd1);
        check("timeout_cycles", 32'(n_wait), 32'd108);
        @(posedge clk); #2;
        check("timeout_one_pulse", 32'(fe_cnt), 32'd1);
        send_byte(8'h01, 1'b0, t_clr);
        repeat (10) @(posedge clk); #2;
        check("timeout_restart_addr", 32'(first_addr), 32'd0);
        check("timeout_restart_bit0", 32'(mem[0]), 32'd1);
        check("timeout_addr_sequence", 32'(addr_err), 32'd0);
`else
        // Without the timeout, frame_err never fires
        n_wait = 0;
        seen = 0;
        check("no_frame_err", 32'(fe_cnt), 32'd0);
`endif

        check("busy_tracking", 32'(busy_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
